// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//   Parametrised up/down counter with configurable width, modulus, step size,
//   and wrap or saturate behaviour. It supports a synchronous clear, a
//   synchronous load that is clamped to the modulus, and boundary status
//   flags.
//
// Parameters
//   WIDTH      counter width in bits (2..32)
//   MAX_VALUE  highest legal count; modulus is MAX_VALUE+1 (< 2**WIDTH)
//   SATURATE   0 = wrap modulo MAX_VALUE+1, 1 = clamp at 0 / MAX_VALUE
//   STEP_W     width of STEP; 2**STEP_W-1 must not exceed MAX_VALUE+1
//
// Ports
//   CLOCK       in   rising-edge clock
//   RESET_N     in   asynchronous active-low reset
//   ENABLE      in   count-enable qualifier
//   DIRECTION   in   1 = up, 0 = down
//   STEP        in   step magnitude (0 holds)
//   LOAD        in   synchronous load strobe
//   LOAD_VALUE  in   value to load (clamped to MAX_VALUE)
//   CLEAR       in   synchronous clear of count and flags
//   COUNT_OUT   out  registered count
//   AT_MAX      out  combinational, COUNT_OUT == MAX_VALUE
//   AT_MIN      out  combinational, COUNT_OUT == 0
//   LIMIT_HIT   out  registered one-cycle pulse on a wrap or clip
//   OVERFLOW    out  sticky copy of LIMIT_HIT, cleared by CLEAR/reset
// ---------------------------------------------------------------------------
module updown_counter_param #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SATURATE  = 0,
  parameter int unsigned     STEP_W    = 2
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              DIRECTION,
  input  logic [STEP_W-1:0] STEP,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  LOAD_VALUE,
  input  logic              CLEAR,
  output logic [WIDTH-1:0]  COUNT_OUT,
  output logic              AT_MAX,
  output logic              AT_MIN,
  output logic              LIMIT_HIT,
  output logic              OVERFLOW
);

  // Elaboration-time legality checks on the parameter set.
  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("updown_counter_param: WIDTH must be in 2..32");
    end
    if (MAX_VALUE >= (64'd1 << WIDTH)) begin : g_bad_max
      $error("updown_counter_param: MAX_VALUE must be < 2**WIDTH");
    end
    if (((64'd1 << STEP_W) - 64'd1) > (MAX_VALUE + 64'd1)) begin : g_bad_step
      $error("updown_counter_param: 2**STEP_W-1 must be <= MAX_VALUE+1");
    end
    if (SATURATE > 1) begin : g_bad_sat
      $error("updown_counter_param: SATURATE must be 0 or 1");
    end
  endgenerate

  // One extra bit so that sums and the modulus itself are representable.
  localparam int unsigned     AW      = WIDTH + 1;
  localparam logic [AW-1:0]    MAX_EXT = AW'(MAX_VALUE);
  localparam logic [AW-1:0]    MOD_EXT = AW'(MAX_VALUE + 64'd1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             limit_hit_q, limit_hit_d;
  logic             overflow_q, overflow_d;

  logic [AW-1:0]    cnt_ext;
  logic [AW-1:0]    step_ext;
  logic [AW-1:0]    load_ext;
  logic [AW-1:0]    sum_up;
  logic [AW-1:0]    diff_dn;
  logic [AW-1:0]    wrap_up;
  logic [AW-1:0]    wrap_dn;
  logic             up_over;
  logic             dn_under;

  // Extended-width arithmetic shared by both directions.
  always_comb begin
    cnt_ext  = {1'b0, count_q};
    step_ext = AW'(STEP);
    load_ext = {1'b0, LOAD_VALUE};
    sum_up   = cnt_ext + step_ext;
    diff_dn  = cnt_ext - step_ext;
    // Wrap results. Each one is only selected when its bound is crossed, so
    // it always lands inside 0..MAX_VALUE.
    wrap_up  = sum_up - MOD_EXT;
    wrap_dn  = cnt_ext + MOD_EXT - step_ext;
    up_over  = (sum_up > MAX_EXT);
    dn_under = (step_ext > cnt_ext);
  end

  // Next-state selection, with priority CLEAR > LOAD > ENABLE > hold.
  always_comb begin
    count_d     = count_q;
    limit_hit_d = 1'b0;
    overflow_d  = overflow_q;

    if (CLEAR) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (LOAD) begin
      // A clamped load is not a counting event, so it raises no flag.
      count_d = (load_ext > MAX_EXT) ? MAX_CNT : LOAD_VALUE;
    end else if (ENABLE) begin
      if (DIRECTION) begin
        if (up_over) begin
          limit_hit_d = 1'b1;
          count_d     = SAT ? MAX_CNT : WIDTH'(wrap_up);
        end else begin
          count_d = WIDTH'(sum_up);
        end
      end else begin
        if (dn_under) begin
          limit_hit_d = 1'b1;
          count_d     = SAT ? '0 : WIDTH'(wrap_dn);
        end else begin
          count_d = WIDTH'(diff_dn);
        end
      end
      overflow_d = overflow_q | limit_hit_d;
    end
  end

  // State registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q     <= '0;
      limit_hit_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      limit_hit_q <= limit_hit_d;
      overflow_q  <= overflow_d;
    end
  end

  assign COUNT_OUT = count_q;
  assign LIMIT_HIT = limit_hit_q;
  assign OVERFLOW  = overflow_q;
  assign AT_MAX    = (count_q == MAX_CNT);
  assign AT_MIN    = (count_q == '0);

endmodule
